// File: rtl/otf_pkg.sv
// Shared types for the on-the-fly quotient builder: FSM states and digit encodings.
package otf_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CONVERT  = 2'd1,
    S_WAIT_REM = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam int ENC_SIGN_MAG = 0;
  localparam int ENC_TWOS     = 1;

endpackage

// File: rtl/otf_digit_decode.sv
// Radix-4 digit decoder: splits a 3-bit code into sign/magnitude, flags illegal codes.
module otf_digit_decode
  import otf_pkg::*;
#(
  parameter int DIGIT_ENC = ENC_SIGN_MAG
) (
  input  logic [2:0] digit,
  output logic       sign,
  output logic [1:0] mag,
  output logic       illegal
);

  // Illegal codes decode as magnitude 0 so the datapath treats them as d=0.
  always_comb begin
    sign    = 1'b0;
    mag     = 2'd0;
    illegal = 1'b0;
    if (DIGIT_ENC == ENC_SIGN_MAG) begin
      if (digit[1:0] == 2'b11) illegal = 1'b1;
      else begin
        sign = digit[2];
        mag  = digit[1:0];
      end
    end else begin
      case (digit)
        3'b000:  ;
        3'b001:  mag = 2'd1;
        3'b010:  mag = 2'd2;
        3'b111:  begin sign = 1'b1; mag = 2'd1; end
        3'b110:  begin sign = 1'b1; mag = 2'd2; end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/otf_quotient_builder.sv
// On-the-fly radix-4 quotient conversion (Q / QM = Q-1 pair) with final remainder correction.
module otf_quotient_builder
  import otf_pkg::*;
#(
  parameter int QW        = 32,
  parameter int DIGIT_ENC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          digit_valid,
  input  logic [2:0]    digit,
  input  logic          rem_valid,
  input  logic          rem_neg,
  output logic [QW-1:0] q_out,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int ND = QW / 2;
  localparam int CW = $clog2(ND + 1);

  state_t        state, state_nxt;
  logic [QW-1:0] q, qm, q_nxt, qm_nxt;
  logic [CW-1:0] cnt;
  logic          sgn, ill;
  logic [1:0]    mag;
  logic          accept, last, take_rem;

  otf_digit_decode #(.DIGIT_ENC(DIGIT_ENC)) u_dec (
    .digit   (digit),
    .sign    (sgn),
    .mag     (mag),
    .illegal (ill)
  );

  // start pre-empts any digit or remainder presented in the same cycle
  assign accept   = (state == S_CONVERT) && digit_valid && !start;
  assign last     = accept && (cnt == CW'(ND - 1));
  assign take_rem = (state == S_WAIT_REM) && rem_valid && !start;

  always_comb begin
    q_nxt  = q;
    qm_nxt = qm;
    if (mag == 2'd0) begin
      q_nxt  = {q[QW-3:0], 2'b00};
      qm_nxt = {qm[QW-3:0], 2'b11};
    end else if (!sgn) begin
      q_nxt  = {q[QW-3:0], mag};
      qm_nxt = {q[QW-3:0], mag - 2'd1};
    end else begin
      q_nxt  = {qm[QW-3:0], 2'(3'd4 - {1'b0, mag})};
      qm_nxt = {qm[QW-3:0], 2'(3'd3 - {1'b0, mag})};
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = S_CONVERT;
    else begin
      case (state)
        S_IDLE:     state_nxt = S_IDLE;
        S_CONVERT:  if (last) state_nxt = S_WAIT_REM;
        S_WAIT_REM: if (take_rem) state_nxt = S_DONE;
        S_DONE:     state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      q     <= '0;
      qm    <= '1;
      cnt   <= '0;
      q_out <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        q   <= '0;
        qm  <= '1;
        cnt <= '0;
        err <= 1'b0;
      end else if (accept) begin
        q   <= q_nxt;
        qm  <= qm_nxt;
        cnt <= cnt + CW'(1);
        err <= err | ill;
      end
      if (take_rem) q_out <= rem_neg ? qm : q;
    end
  end

  always_comb begin
    busy = (state == S_CONVERT) || (state == S_WAIT_REM);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_otf_quotient_builder.sv
// Directed + randomized bench: models the quotient as a plain radix-4 sum modulo 2^QW.
module tb_otf_quotient_builder;

  localparam int QW = 8;

  logic       clk = 1'b0;
  logic       rst_n, start, digit_valid, rem_valid, rem_neg;
  logic [2:0] digit0, digit1;
  logic [QW-1:0] q0, q1;
  logic done0, done1, busy0, busy1, err0, err1;

  int n_chk = 0;
  int n_err = 0;

  int          qv;
  int          nacc;
  bit          ill_seen;
  logic [QW-1:0] last_q;

  always #5 clk = ~clk;

  otf_quotient_builder #(.QW(QW), .DIGIT_ENC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid), .digit(digit0),
    .rem_valid(rem_valid), .rem_neg(rem_neg), .q_out(q0), .done(done0), .busy(busy0), .err(err0)
  );

  otf_quotient_builder #(.QW(QW), .DIGIT_ENC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid), .digit(digit1),
    .rem_valid(rem_valid), .rem_neg(rem_neg), .q_out(q1), .done(done1), .busy(busy1), .err(err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] enc0(input int d, input bit alt);
    case (d)
      1:       return 3'b001;
      2:       return 3'b010;
      -1:      return 3'b101;
      -2:      return 3'b110;
      default: return alt ? 3'b100 : 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] enc1(input int d);
    case (d)
      1:       return 3'b001;
      2:       return 3'b010;
      -1:      return 3'b111;
      -2:      return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    qv = 0; nacc = 0; ill_seen = 1'b0;
    chk("start_busy0", busy0, 1'b1);
    chk("start_busy1", busy1, 1'b1);
    chk("start_err0", err0, 1'b0);
    chk("start_hold_q0", q0, last_q);
    chk("start_hold_q1", q1, last_q);
  endtask

  task automatic feed(input int d, input bit illegal);
    logic [2:0] ill0 [2];
    logic [2:0] ill1 [3];
    ill0 = '{3'b011, 3'b111};
    ill1 = '{3'b011, 3'b100, 3'b101};
    if (illegal) begin
      digit0 = ill0[$urandom_range(0, 1)];
      digit1 = ill1[$urandom_range(0, 2)];
      d = 0;
      ill_seen = 1'b1;
    end else begin
      digit0 = enc0(d, 1'($urandom_range(0, 1)));
      digit1 = enc1(d);
    end
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    qv = (qv * 4 + d) & ((1 << QW) - 1);
    nacc++;
  endtask

  task automatic finish_conv(input bit neg);
    logic [QW-1:0] exp;
    chk("wait_busy", busy0, 1'b1);
    chk("pre_done", done0, 1'b0);
    rem_valid = 1'b1;
    rem_neg   = neg;
    tick();
    rem_valid = 1'b0;
    exp = QW'((qv - int'(neg)) & ((1 << QW) - 1));
    last_q = exp;
    chk("done0", done0, 1'b1);
    chk("done1", done1, 1'b1);
    chk("q0", q0, exp);
    chk("q1", q1, exp);
    chk("err0", err0, ill_seen);
    chk("err1", err1, ill_seen);
    tick();
    chk("done_pulse", done0, 1'b0);
    chk("idle_busy", busy0, 1'b0);
    chk("q_hold", q0, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; digit_valid = 1'b0; rem_valid = 1'b0; rem_neg = 1'b0;
    digit0 = 3'b000; digit1 = 3'b000; last_q = '0;
    qv = 0; nacc = 0; ill_seen = 1'b0;
    #12;
    chk("rst_q", q0, 8'h00);
    chk("rst_done", done0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_err", err0, 1'b0);
    chk("rst_qm", dut0.qm, 8'hFF);
    rst_n = 1'b1;
    tick();

    // rem_valid in IDLE is ignored
    rem_valid = 1'b1; rem_neg = 1'b1;
    tick();
    rem_valid = 1'b0;
    chk("idle_rem_done", done0, 1'b0);
    chk("idle_rem_q", q0, 8'h00);

    do_start();
    feed(2, 0); feed(-1, 0); feed(0, 0); feed(1, 0);
    chk("q71_model", qv, 32'h71);
    finish_conv(0);

    do_start();
    feed(2, 0); feed(-1, 0); feed(0, 0); feed(1, 0);
    finish_conv(1);
    chk("q70", q0, 8'h70);

    do_start();
    feed(-1, 0); chk("enc1_q_ff", dut1.q, 8'hFF);
    feed(2, 0);  chk("enc1_q_fe", dut1.q, 8'hFE);
    feed(2, 0);  chk("enc1_q_fa", dut1.q, 8'hFA);
    feed(2, 0);
    finish_conv(0);
    chk("qea", q1, 8'hEA);

    do_start();
    feed(1, 0); feed(0, 1);
    chk("ill_err0", err0, 1'b1);
    chk("ill_err1", err1, 1'b1);
    feed(2, 0); feed(-2, 0);
    finish_conv(0);
    do_start();
    chk("err_cleared", err1, 1'b0);

    // start collides with a digit: digit dropped, state cleared
    feed(1, 0); feed(2, 0);
    digit0 = enc0(2, 0); digit1 = enc1(2);
    digit_valid = 1'b1; start = 1'b1;
    tick();
    digit_valid = 1'b0; start = 1'b0;
    qv = 0; nacc = 0; ill_seen = 1'b0;
    chk("coll_cnt", dut0.cnt, 0);
    chk("coll_q", dut0.q, 8'h00);
    chk("coll_busy", busy0, 1'b1);
    feed(-2, 0); feed(1, 0);
    // rem_valid in CONVERT is ignored
    rem_valid = 1'b1;
    tick();
    rem_valid = 1'b0;
    chk("conv_rem_done", done0, 1'b0);
    chk("conv_rem_busy", busy0, 1'b1);
    feed(0, 0); feed(2, 0);
    finish_conv(1);

    for (int it = 0; it < 40; it++) begin
      do_start();
      while (nacc < QW / 2) begin
        if ($urandom_range(0, 3) == 0) begin
          rem_valid = 1'($urandom_range(0, 1));
          tick();
          rem_valid = 1'b0;
        end
        feed($urandom_range(0, 4) - 2, $urandom_range(0, 7) == 0);
      end
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        digit_valid = 1'b1;
        digit0 = 3'b001; digit1 = 3'b001;
        tick();
        digit_valid = 1'b0;
      end
      finish_conv(1'($urandom_range(0, 1)));
    end

    // reset during WAIT_REM aborts without a done pulse
    do_start();
    feed(1, 0); feed(0, 1); feed(2, 0); feed(-1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q0, 8'h00);
    chk("arst_done", done0, 1'b0);
    chk("arst_busy", busy0, 1'b0);
    chk("arst_err", err0, 1'b0);
    rem_valid = 1'b1; start = 1'b1;
    tick();
    chk("arst_hold_done", done0, 1'b0);
    chk("arst_hold_busy", busy0, 1'b0);
    rst_n = 1'b1; start = 1'b0;
    tick();
    rem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_done", done0, 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
